// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch queue. It issues sequential word fetches to the arbiter's
// instruction port, buffers the returned {addr, data} pairs in a small FIFO for
// the core fetch stage, and handles flush redirects and requests still in flight.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr,
  input  logic        instr_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_next, rptr_next;
  logic [CW-1:0] count, count_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   req_addr, req_addr_next;
  logic          pending, pending_next;
  logic          discard, discard_next;
  logic          head_valid, retire, busy, push, pop, issue;
  logic [31:0]   flush_pc;
  logic          unused_flush_lsb;

  // Word alignment drops the two low bits of the redirect target.
  assign unused_flush_lsb = ^flush_addr[1:0];

  // Next-state: response retirement, FIFO push/pop, flush redirect and issue.
  always_comb begin
    flush_pc   = {flush_addr[31:2], 2'b00};
    head_valid = (count != '0);
    retire     = pending & mem_ready;
    busy       = pending & ~mem_ready;
    // A flush in the same cycle drops the returning word.
    push       = retire & ~discard & ~flush;
    pop        = head_valid & instr_ready & ~flush;

    wptr_next  = wptr + PW'(push);
    if (flush) begin
      count_next = '0;
      rptr_next  = wptr;
    end else begin
      count_next = count + CW'(push) - CW'(pop);
      rptr_next  = rptr + PW'(pop);
    end

    if (flush)     fetch_pc_next = flush_pc;
    else if (push) fetch_pc_next = fetch_pc + 32'd4;
    else           fetch_pc_next = fetch_pc;

    // Only issue when the response is guaranteed a free slot.
    issue        = (~pending | retire) & (count_next < DEPTH_C);
    pending_next = busy | issue;
    // The outstanding address stays put until its mem_ready cycle.
    req_addr_next = busy ? req_addr : fetch_pc_next;

    if (flush & busy) discard_next = 1'b1;
    else if (retire)  discard_next = 1'b0;
    else              discard_next = discard;
  end

  // Outputs: request side mirrors next-state so the arbiter never sees a stale request.
  always_comb begin
    mem_valid   = pending_next & ~reset;
    mem_instr   = mem_valid;
    mem_addr    = mem_valid ? req_addr_next : 32'h0;
    mem_wdata   = 32'h0;
    mem_wstrb   = 4'h0;
    instr_valid = head_valid & ~reset;
    instr_data  = instr_valid ? fifo_data[rptr] : 32'h0;
    instr_addr  = instr_valid ? fifo_addr[rptr] : 32'h0;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      pending  <= 1'b0;
      discard  <= 1'b0;
      fetch_pc <= RESET_ADDR;
    end else begin
      count    <= count_next;
      wptr     <= wptr_next;
      rptr     <= rptr_next;
      pending  <= pending_next;
      discard  <= discard_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // FIFO storage and outstanding-request address; gated by control, not reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wptr] <= req_addr;
      fifo_data[wptr] <= mem_rdata;
    end
    req_addr <= req_addr_next;
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: a cycle-exact vector table, directed corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_fetch_prefetch_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_A = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset, flush, instr_ready, mem_ready;
  logic [31:0] flush_addr, mem_rdata;
  logic        instr_valid, mem_valid, mem_instr;
  logic [31:0] instr_data, instr_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  always #5 clock = ~clock;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clock(clock), .reset(reset), .flush(flush), .flush_addr(flush_addr),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
    .instr_ready(instr_ready), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory/core model state
  logic        m_busy, m_live, cur_mready;
  logic [31:0] m_addr, exp_req;
  int          m_cd, n_req, n_pop, lat_lo, lat_hi;
  logic [31:0] q_addr[$];
  logic [31:0] pop_log[$];
  bit          c_flush, c_ready;
  logic [31:0] c_faddr;

  task automatic model_reset();
    m_busy = 1'b0; m_live = 1'b0; m_cd = 0;
    q_addr.delete(); pop_log.delete();
    exp_req = RST_A; n_req = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_valid"},   {31'b0, mem_valid},   32'h0);
    chk({tag, "_mem_instr"},   {31'b0, mem_instr},   32'h0);
    chk({tag, "_mem_addr"},    mem_addr,             32'h0);
    chk({tag, "_mem_wdata"},   mem_wdata,            32'h0);
    chk({tag, "_mem_wstrb"},   {28'b0, mem_wstrb},   32'h0);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_instr_addr"},  instr_addr,           32'h0);
    chk({tag, "_instr_data"},  instr_data,           32'h0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; flush = 1'b0; flush_addr = 32'h0; instr_ready = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    @(posedge clock); #5;
    chk_all_zero("reset");
  endtask

  // One cycle of randomized/controlled traffic against the queue model.
  task automatic auto_cycle();
    int pre;
    @(posedge clock); #1;
    reset = 1'b0;
    cur_mready = m_busy && (m_cd == 0);
    if (m_busy && m_cd != 0) m_cd--;
    mem_ready   = cur_mready;
    mem_rdata   = cur_mready ? memf(m_addr) : $urandom();
    flush       = c_flush;
    flush_addr  = c_faddr;
    instr_ready = c_ready;
    #4;
    pre = q_addr.size();
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, pre != 0});
    if (pre != 0) begin
      chk("instr_addr", instr_addr, q_addr[0]);
      chk("instr_data", instr_data, memf(q_addr[0]));
    end else begin
      chk("instr_addr_empty", instr_addr, 32'h0);
      chk("instr_data_empty", instr_data, 32'h0);
    end
    chk("mem_instr", {31'b0, mem_instr}, {31'b0, mem_valid});
    chk("mem_wdata", mem_wdata, 32'h0);
    chk("mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    if (cur_mready) begin
      if (m_live && !c_flush) q_addr.push_back(m_addr);
      m_busy = 1'b0;
    end
    if (c_flush) begin
      if (m_busy) m_live = 1'b0;
      q_addr.delete();
      pop_log.delete();
      exp_req = {c_faddr[31:2], 2'b00};
    end else if (pre != 0 && c_ready) begin
      pop_log.push_back(q_addr[0]);
      void'(q_addr.pop_front());
      n_pop++;
    end
    if (m_busy) begin
      chk("mem_valid_hold", {31'b0, mem_valid}, 32'h1);
      chk("mem_addr_hold", mem_addr, m_addr);
    end else begin
      chk("mem_valid_issue", {31'b0, mem_valid}, {31'b0, q_addr.size() < DEPTH});
      if (mem_valid) begin
        chk("mem_addr", mem_addr, exp_req);
        m_busy = 1'b1; m_live = 1'b1; m_addr = exp_req;
        m_cd = int'($urandom_range(lat_hi, lat_lo)) - 1;
        exp_req = exp_req + 32'd4;
        n_req++;
      end
    end
  endtask

  typedef struct {
    bit fl; logic [31:0] fa; bit ir; bit mr; logic [31:0] ra;
    bit mv; logic [31:0] ma; bit iv; logic [31:0] ia;
  } vec_t;

  function automatic vec_t mk(bit fl, logic [31:0] fa, bit ir, bit mr, logic [31:0] ra,
                              bit mv, logic [31:0] ma, bit iv, logic [31:0] ia);
    vec_t v;
    v.fl = fl; v.fa = fa; v.ir = ir; v.mr = mr; v.ra = ra;
    v.mv = mv; v.ma = ma; v.iv = iv; v.ia = ia;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int guard;
    logic [31:0] exp_id;
    n_pop = 0; lat_lo = 1; lat_hi = 1;
    c_flush = 0; c_ready = 1; c_faddr = 32'h0;

    // Cycle-exact table from reset release; 1-2 cycle memory, flush while busy,
    // flush together with mem_ready, simultaneous pop and push.
    tbl[0]  = mk(0, 32'h0,    1, 0, 32'h0,    1, 32'h0,    0, 32'h0);
    tbl[1]  = mk(0, 32'h0,    1, 1, 32'h0,    1, 32'h4,    0, 32'h0);
    tbl[2]  = mk(0, 32'h0,    1, 1, 32'h4,    1, 32'h8,    1, 32'h0);
    tbl[3]  = mk(0, 32'h0,    1, 0, 32'h0,    1, 32'h8,    1, 32'h4);
    tbl[4]  = mk(0, 32'h0,    1, 1, 32'h8,    1, 32'hC,    0, 32'h0);
    tbl[5]  = mk(1, 32'h1003, 1, 0, 32'h0,    1, 32'hC,    1, 32'h8);
    tbl[6]  = mk(0, 32'h0,    1, 1, 32'hC,    1, 32'h1000, 0, 32'h0);
    tbl[7]  = mk(0, 32'h0,    1, 1, 32'h1000, 1, 32'h1004, 0, 32'h0);
    tbl[8]  = mk(1, 32'h20,   1, 1, 32'h1004, 1, 32'h20,   1, 32'h1000);
    tbl[9]  = mk(0, 32'h0,    1, 0, 32'h0,    1, 32'h20,   0, 32'h0);
    tbl[10] = mk(0, 32'h0,    1, 1, 32'h20,   1, 32'h24,   0, 32'h0);
    tbl[11] = mk(0, 32'h0,    0, 0, 32'h0,    1, 32'h24,   1, 32'h20);
    tbl[12] = mk(0, 32'h0,    1, 1, 32'h24,   1, 32'h28,   1, 32'h20);
    tbl[13] = mk(0, 32'h0,    1, 0, 32'h0,    1, 32'h28,   1, 32'h24);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      reset = 1'b0;
      flush = tbl[i].fl; flush_addr = tbl[i].fa; instr_ready = tbl[i].ir;
      mem_ready = tbl[i].mr;
      mem_rdata = tbl[i].mr ? memf(tbl[i].ra) : 32'hBAD0_BAD0;
      #4;
      chk($sformatf("tbl%0d_mem_valid", i), {31'b0, mem_valid}, {31'b0, tbl[i].mv});
      if (tbl[i].mv) chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].ma);
      chk($sformatf("tbl%0d_instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].iv});
      exp_id = tbl[i].iv ? memf(tbl[i].ia) : 32'h0;
      chk($sformatf("tbl%0d_instr_addr", i), instr_addr, tbl[i].iv ? tbl[i].ia : 32'h0);
      chk($sformatf("tbl%0d_instr_data", i), instr_data, exp_id);
    end

    // Fill with the core stalled, then a single pop reopens exactly one fetch.
    do_reset(); model_reset();
    c_ready = 0; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 14; i++) auto_cycle();
    chk("fill_requests", n_req, 32'd4);
    chk("fill_valid", {31'b0, instr_valid}, 32'h1);
    c_ready = 1; auto_cycle();
    c_ready = 0;
    for (int i = 0; i < 6; i++) auto_cycle();
    chk("refill_requests", n_req, 32'd5);
    chk("refill_last_addr", m_addr, 32'h10);

    // Redirect near the top of the address space wraps to zero.
    do_reset(); model_reset();
    c_ready = 1; lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 3; i++) auto_cycle();
    c_flush = 1; c_faddr = 32'hFFFF_FFFA; auto_cycle(); c_flush = 0;
    for (int i = 0; i < 16; i++) auto_cycle();
    if (pop_log.size() >= 3) begin
      chk("wrap_pop0", pop_log[0], 32'hFFFF_FFF8);
      chk("wrap_pop1", pop_log[1], 32'hFFFF_FFFC);
      chk("wrap_pop2", pop_log[2], 32'h0000_0000);
    end else chk("wrap_pop_count", pop_log.size(), 32'd3);

    // Reset while a request is outstanding and two entries are buffered.
    do_reset(); model_reset();
    c_ready = 0; lat_lo = 3; lat_hi = 3;
    guard = 0;
    while (!(q_addr.size() == 2 && m_busy) && guard < 40) begin
      auto_cycle(); guard++;
    end
    chk("rst_setup_reached", {31'b0, guard < 40}, 32'h1);
    @(posedge clock); #1;
    reset = 1'b1; mem_ready = 1'b0; flush = 1'b0;
    #4;
    chk_all_zero("rst_mid");
    @(posedge clock); #1;
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
    #4;
    chk("rst_stray_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_refetch_valid", {31'b0, mem_valid}, 32'h1);
    chk("rst_refetch_addr", mem_addr, RST_A);
    model_reset();
    lat_lo = 2; lat_hi = 2;
    m_busy = 1'b1; m_live = 1'b1; m_addr = RST_A; m_cd = 1;
    exp_req = RST_A + 32'd4; n_req = 1;
    c_ready = 1;
    for (int i = 0; i < 8; i++) auto_cycle();
    if (pop_log.size() != 0) chk("rst_first_pop", pop_log[0], RST_A);
    else chk("rst_pop_count", pop_log.size(), 32'd1);

    // Randomized traffic with stalls, variable latency and redirects.
    do_reset(); model_reset();
    lat_lo = 1; lat_hi = 4;
    n_pop = 0;
    for (int i = 0; i < 3000; i++) begin
      c_ready = (i % 200 < 150) ? ($urandom_range(9, 0) < 7) : ($urandom_range(9, 0) < 1);
      c_flush = ($urandom_range(24, 0) == 0);
      c_faddr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom();
      auto_cycle();
    end
    c_flush = 0;
    chk("random_liveness", {31'b0, n_pop > 300}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
